// File: rtl/bram_rsp_port.sv
// bram_rsp_port: single-port BRAM command front-end with a 3-entry read-response FIFO
module bram_rsp_port #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);
  logic [DATA_W-1:0] mem [3];
  logic [1:0] count, wr_ptr, rd_ptr;
  logic rd_inflight, accept, push, pop;
  // credit check reserves a slot for the read already in the BRAM pipeline
  always_comb begin
    req_ready  = ~rst & (({1'b0, count} + {2'b0, rd_inflight}) < 3'd3);
    accept     = req_valid & req_ready;
    bram_en    = accept;
    bram_we    = accept & req_we;
    bram_addr  = req_addr;
    bram_din   = req_wdata;
    push       = rd_inflight;
    resp_valid = count != 2'd0;
    pop        = resp_valid & resp_ready;
    resp_rdata = mem[rd_ptr];
  end
  // pointers, occupancy and in-flight tracking; reset drops any pending read
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= 2'd0;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= accept & ~req_we;
      count       <= count + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
    end
  end
  // capture BRAM read data the cycle after the read was issued
  always_ff @(posedge clk) begin
    if (push & ~rst) mem[wr_ptr] <= bram_dout;
  end
endmodule

// File: tb/tb_bram_rsp_port.sv
// tb_bram_rsp_port: scoreboard bench for bram_rsp_port with a behavioural BRAM
module tb_bram_rsp_port;
  localparam int AW = 7;
  localparam int DW = 32;
  typedef struct {logic [DW-1:0] data; int lat; int acc;} exp_t;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, resp_valid, resp_ready = 0;
  logic [AW-1:0] req_addr = 0, bram_addr;
  logic [DW-1:0] req_wdata = 0, resp_rdata, bram_din, bram_dout;
  logic bram_en, bram_we;
  logic [DW-1:0] bmem [128];
  logic [DW-1:0] ref_mem [128];
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0;

  bram_rsp_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial for (int i = 0; i < 128; i++) begin bmem[i] = '0; ref_mem[i] = '0; end

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bmem[bram_addr] <= bram_din;
      bram_dout <= bmem[bram_addr];
    end
  end

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got %h expected no response (cycle %0d)", resp_rdata, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", resp_rdata, e.data);
        if (e.lat != 0) chk("resp_latency", DW'(cyc - e.acc), DW'(e.lat));
      end
    end
  end

  task automatic drive(bit v, bit we, int a, logic [DW-1:0] d, logic [DW-1:0] exp, int lat,
                       bit nopush, output bit acc);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_addr = AW'(a); req_wdata = d;
    #1;
    acc = v && req_ready;
    if (v) begin
      chk("bram_en", 32'(bram_en), 32'(acc));
      chk("bram_we", 32'(bram_we), 32'(acc && we));
    end
    if (acc) begin
      chk("bram_addr", 32'(bram_addr), 32'(a));
      if (we) ref_mem[a] = d;
      else if (!nopush) q.push_back('{exp, lat, cyc});
    end
  endtask

  task automatic idle(int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(0, 0, 0, '0, '0, 0, 0, acc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    resp_ready = 1;
    while ((q.size() != 0 || resp_valid) && t < 50) begin idle(1); t++; end
    idle(1);
    chk("drain_queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    drive(1, 1, 3, 32'hdead, '0, 0, 0, acc);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    @(posedge clk); #1 rst = 0; req_valid = 0; #1;
    chk("ready_after_rst", 32'(req_ready), 1);
    resp_ready = 1;
    drive(1, 1, 0, 32'h12345678, '0, 0, 0, acc);
    drive(1, 1, 1, 32'h98765432, '0, 0, 0, acc);
    drive(1, 0, 1, '0, 32'h98765432, 2, 0, acc);
    idle(3);
    drive(1, 1, 1, 32'h89abcdef, '0, 0, 0, acc);
    drive(1, 0, 1, '0, 32'h89abcdef, 2, 0, acc);
    drive(1, 0, 0, '0, 32'h12345678, 2, 0, acc);
    drain();
    for (int i = 0; i < 16; i++) drive(1, 1, i, 32'ha5000000 | i, '0, 0, 0, acc);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, i, '0, 32'ha5000000 | i, 2, 0, acc);
      chk("b2b_ready", 32'(acc), 1);
    end
    drain();
    resp_ready = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 4 + i, '0, 32'ha5000004 + i, 0, 0, acc);
      n += int'(acc);
    end
    chk("full_accepts", 32'(n), 3);
    chk("full_ready_low", 32'(req_ready), 0);
    chk("hold_valid", 32'(resp_valid), 1);
    chk("hold_data0", resp_rdata, 32'ha5000004);
    idle(2);
    chk("hold_data1", resp_rdata, 32'ha5000004);
    req_valid = 0;
    resp_ready = 1;
    n = 0;
    while (!req_ready && n < 5) begin idle(1); n++; end
    chk("ready_returns", 32'(req_ready), 1);
    drain();
    drive(1, 0, 2, '0, '0, 0, 1, acc);
    chk("rst_read_accepted", 32'(acc), 1);
    @(posedge clk); #1 rst = 1; req_valid = 1; req_we = 0; #1;
    chk("rst_ready_low", 32'(req_ready), 0);
    chk("rst_bram_en", 32'(bram_en), 0);
    @(posedge clk); #1 rst = 0; req_valid = 0; #1;
    chk("post_rst_ready", 32'(req_ready), 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("discarded_read", 32'(resp_valid), 0);
    end
    for (int i = 0; i < 10000; i++) begin
      int a;
      bit we;
      a = int'($urandom_range(0, 127));
      we = ($urandom_range(0, 2) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, we, a, $urandom, ref_mem[a], 0, 0, acc);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
